// File: rtl/cnn_window_gen_if.sv
// Stream bundle between a raster pixel source, the window generator and a kernel.
// The slave side (the window generator) consumes pixels and produces windows.
interface cnn_window_gen_if #(
    parameter int KX     = 3,
    parameter int KY     = 3,
    parameter int I_F_BW = 8
);
    logic                     in_valid_i;
    logic [I_F_BW-1:0]        in_pixel_i;
    logic                     ot_valid_o;
    logic [KX*KY*I_F_BW-1:0]  ot_f_map_o;
    logic                     ot_last_o;
    logic                     ot_frame_done_o;

    modport master (
        output in_valid_i,
        output in_pixel_i,
        input  ot_valid_o,
        input  ot_f_map_o,
        input  ot_last_o,
        input  ot_frame_done_o
    );

    modport slave (
        input  in_valid_i,
        input  in_pixel_i,
        output ot_valid_o,
        output ot_f_map_o,
        output ot_last_o,
        output ot_frame_done_o
    );
endinterface

// File: rtl/cnn_window_gen.sv
// Sliding KX x KY window generator over a raster pixel stream (stride 1, no padding).
// KY-1 shift-register line buffers feed the rightmost window column each accepted pixel.
module cnn_window_gen #(
    parameter int KX     = 3,
    parameter int KY     = 3,
    parameter int I_F_BW = 8,
    parameter int IX     = 8,
    parameter int IY     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             soft_reset_i,
    cnn_window_gen_if.slave  bus
);
    localparam int CW = (IX > 1) ? $clog2(IX) : 1;
    localparam int RW = (IY > 1) ? $clog2(IY) : 1;
    localparam int MW = KX * KY * I_F_BW;

    localparam logic [CW-1:0] COL_LAST      = CW'(IX - 1);
    localparam logic [CW-1:0] COL_FIRST_OUT = CW'(KX - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IY - 1);
    localparam logic [RW-1:0] ROW_FIRST_OUT = RW'(KY - 1);

    logic              flush;
    logic              accept;
    logic [CW-1:0]     colCnt_q, colCnt_d;
    logic [RW-1:0]     rowCnt_q, rowCnt_d;
    logic              valid_q, valid_d;
    logic              last_q, last_d;
    logic              done_q, done_d;
    logic [I_F_BW-1:0] win_q [KX][KY];
    logic [I_F_BW-1:0] win_d [KX][KY];
    logic [I_F_BW-1:0] line_q [KY-1][IX];
    logic [I_F_BW-1:0] lineIn [KY-1];
    logic [MW-1:0]     fMap;

    // A pixel offered during a flush cycle is dropped, not half-accepted.
    assign flush  = reset || soft_reset_i;
    assign accept = bus.in_valid_i && !flush;

    always_comb begin
        colCnt_d = colCnt_q;
        rowCnt_d = rowCnt_q;
        win_d    = win_q;
        valid_d  = 1'b0;
        last_d   = 1'b0;
        done_d   = 1'b0;
        if (accept) begin
            if (colCnt_q == COL_LAST) begin
                colCnt_d = '0;
                rowCnt_d = (rowCnt_q == ROW_LAST) ? '0 : rowCnt_q + 1'b1;
            end else begin
                colCnt_d = colCnt_q + 1'b1;
            end
            for (int x = 0; x < KX - 1; x++) begin
                for (int y = 0; y < KY; y++) begin
                    win_d[x][y] = win_q[x + 1][y];
                end
            end
            for (int y = 0; y < KY - 1; y++) begin
                win_d[KX-1][y] = line_q[y][IX-1];
            end
            win_d[KX-1][KY-1] = bus.in_pixel_i;
            valid_d = (rowCnt_q >= ROW_FIRST_OUT) && (colCnt_q >= COL_FIRST_OUT);
            last_d  = (rowCnt_q == ROW_LAST) && (colCnt_q == COL_LAST);
            done_d  = last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            colCnt_q <= '0;
            rowCnt_q <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int x = 0; x < KX; x++) begin
                for (int y = 0; y < KY; y++) begin
                    win_q[x][y] <= '0;
                end
            end
        end else begin
            colCnt_q <= colCnt_d;
            rowCnt_q <= rowCnt_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
            done_q   <= done_d;
            win_q    <= win_d;
        end
    end

    // Each line buffer is fed by the tail of the next-newer one; the newest takes the live pixel.
    always_comb begin
        for (int k = 0; k < KY - 2; k++) begin
            lineIn[k] = line_q[k + 1][IX-1];
        end
        lineIn[KY-2] = bus.in_pixel_i;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < KY - 1; k++) begin
                for (int j = IX - 1; j > 0; j--) begin
                    line_q[k][j] <= line_q[k][j - 1];
                end
                line_q[k][0] <= lineIn[k];
            end
        end
    end

    always_comb begin
        fMap = '0;
        for (int x = 0; x < KX; x++) begin
            for (int y = 0; y < KY; y++) begin
                fMap[((KY * x) + y) * I_F_BW +: I_F_BW] = win_q[x][y];
            end
        end
    end

    assign bus.ot_f_map_o      = fMap;
    assign bus.ot_valid_o      = valid_q;
    assign bus.ot_last_o       = last_q;
    assign bus.ot_frame_done_o = done_q;
endmodule

// File: tb/tb_cnn_window_gen.sv
// Directed bench for cnn_window_gen: 4x4 frames from a vector table, reset/idle corners,
// and an 8x8 instance whose windows feed a 3x3 weighted sum checked against the image.
module tb_cnn_window_gen;
    typedef struct packed {
        logic [7:0]  pixel;
        logic        expValid;
        logic        expLast;
        logic        expDone;
        logic [71:0] expMap;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic softReset;
    int   compared = 0;
    int   mismatched = 0;
    vec_t vecs [16];
    int   img [64];

    always #5 clk = ~clk;

    cnn_window_gen_if #(.KX(3), .KY(3), .I_F_BW(8)) bus4 ();
    cnn_window_gen_if #(.KX(3), .KY(3), .I_F_BW(8)) bus8 ();

    cnn_window_gen #(.KX(3), .KY(3), .I_F_BW(8), .IX(4), .IY(4)) dut4 (
        .clk          (clk),
        .reset        (reset),
        .soft_reset_i (softReset),
        .bus          (bus4)
    );

    cnn_window_gen #(.KX(3), .KY(3), .I_F_BW(8), .IX(8), .IY(8)) dut8 (
        .clk          (clk),
        .reset        (reset),
        .soft_reset_i (softReset),
        .bus          (bus8)
    );

    task automatic checkOutput(input string name, input logic [71:0] actual, input logic [71:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic applyStimulus(input logic valid, input logic [7:0] pixel, input logic rst,
                                 input logic srst, input logic big);
        @(negedge clk);
        reset             = rst;
        softReset         = srst;
        bus4.in_valid_i   = valid && !big;
        bus4.in_pixel_i   = pixel;
        bus8.in_valid_i   = valid && big;
        bus8.in_pixel_i   = pixel;
        @(posedge clk);
        #1;
    endtask

    task automatic applyVector(input int idx, input int base, input string tag);
        logic [71:0] expMap;
        applyStimulus(1'b1, vecs[idx].pixel + 8'(base), 1'b0, 1'b0, 1'b0);
        checkOutput({tag, "_valid"}, 72'(bus4.ot_valid_o), 72'(vecs[idx].expValid));
        checkOutput({tag, "_last"}, 72'(bus4.ot_last_o), 72'(vecs[idx].expLast));
        checkOutput({tag, "_done"}, 72'(bus4.ot_frame_done_o), 72'(vecs[idx].expDone));
        if (vecs[idx].expValid) begin
            expMap = vecs[idx].expMap;
            for (int e = 0; e < 9; e++) begin
                expMap[e*8 +: 8] = expMap[e*8 +: 8] + 8'(base);
            end
            checkOutput({tag, "_map"}, bus4.ot_f_map_o, expMap);
        end
    endtask

    task automatic idleCheck(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
            checkOutput({tag, "_idleValid"}, 72'(bus4.ot_valid_o), 72'(0));
            checkOutput({tag, "_idleDone"}, 72'(bus4.ot_frame_done_o), 72'(0));
        end
    endtask

    task automatic runFrame(input int base, input int maxGap, input string tag);
        for (int i = 0; i < 16; i++) begin
            applyVector(i, base, tag);
            if (maxGap > 0) idleCheck($urandom_range(0, maxGap), tag);
        end
    endtask

    task automatic checkFlushed(input string tag);
        checkOutput({tag, "_valid"}, 72'(bus4.ot_valid_o), 72'(0));
        checkOutput({tag, "_map"}, bus4.ot_f_map_o, 72'(0));
        checkOutput({tag, "_last"}, 72'(bus4.ot_last_o), 72'(0));
        checkOutput({tag, "_done"}, 72'(bus4.ot_frame_done_o), 72'(0));
    endtask

    function automatic int kernelSum(input logic [71:0] m);
        int s = 0;
        for (int x = 0; x < 3; x++) begin
            for (int y = 0; y < 3; y++) begin
                s += (x + 1 + 3 * y) * int'(m[((3 * x) + y) * 8 +: 8]);
            end
        end
        return s;
    endfunction

    initial begin
        int r, c, refSum, windows;
        logic expV;

        reset           = 1'b1;
        softReset       = 1'b0;
        bus4.in_valid_i = 1'b0;
        bus4.in_pixel_i = '0;
        bus8.in_valid_i = 1'b0;
        bus8.in_pixel_i = '0;

        // 4x4 frame, p = 4*row+col; windows follow pixels 10, 11, 14, 15 with element (x,y) = pixel(r-2+y, c-2+x)
        for (int p = 0; p < 16; p++) begin
            r = p / 4;
            c = p % 4;
            vecs[p].pixel    = 8'(p);
            vecs[p].expValid = (p == 10) || (p == 11) || (p == 14) || (p == 15);
            vecs[p].expLast  = (p == 15);
            vecs[p].expDone  = (p == 15);
            vecs[p].expMap   = '0;
            if (vecs[p].expValid) begin
                for (int x = 0; x < 3; x++) begin
                    for (int y = 0; y < 3; y++) begin
                        vecs[p].expMap[((3 * x) + y) * 8 +: 8] = 8'(4 * (r - 2 + y) + (c - 2 + x));
                    end
                end
            end
        end

        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        checkFlushed("reset");
        checkOutput("reset8_valid", 72'(bus8.ot_valid_o), 72'(0));

        runFrame(0, 0, "frameA");
        runFrame(100, 0, "frameB");

        runFrame(0, 3, "gaps");

        for (int i = 0; i < 10; i++) applyVector(i, 0, "preRst");
        applyStimulus(1'b1, 8'h37, 1'b1, 1'b0, 1'b0);
        checkFlushed("midReset");
        runFrame(0, 0, "afterRst");

        for (int i = 0; i < 10; i++) applyVector(i, 0, "preSoft");
        applyStimulus(1'b1, 8'h37, 1'b0, 1'b1, 1'b0);
        checkFlushed("midSoft");
        runFrame(0, 0, "afterSoft");

        for (int i = 0; i < 10; i++) applyVector(i, 0, "stall");
        idleCheck(20, "stall");
        for (int i = 10; i < 16; i++) applyVector(i, 0, "resume");

        // 8x8 random frames; each window's 3x3 weighted sum must match the sum over the stored image
        for (int f = 0; f < 3; f++) begin
            windows = 0;
            for (int p = 0; p < 64; p++) begin
                img[p] = $urandom_range(0, 255);
                applyStimulus(1'b1, 8'(img[p]), 1'b0, 1'b0, 1'b1);
                r = p / 8;
                c = p % 8;
                expV = (r >= 2) && (c >= 2);
                checkOutput("big_valid", 72'(bus8.ot_valid_o), 72'(expV));
                checkOutput("big_last", 72'(bus8.ot_last_o), 72'(p == 63));
                if (bus8.ot_valid_o) windows++;
                if (expV) begin
                    refSum = 0;
                    for (int x = 0; x < 3; x++) begin
                        for (int y = 0; y < 3; y++) begin
                            refSum += (x + 1 + 3 * y) * img[(r - 2 + y) * 8 + (c - 2 + x)];
                        end
                    end
                    checkOutput("big_kernel", 72'(kernelSum(bus8.ot_f_map_o)), 72'(refSum));
                end
                if ($urandom_range(0, 3) == 0) begin
                    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
                    checkOutput("big_idleValid", 72'(bus8.ot_valid_o), 72'(0));
                end
            end
            checkOutput("big_windows", 72'(windows), 72'(36));
        end

        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/cnn_window_gen.md
Name: cnn_window_gen

Overview:
- Window generator that drives the kernel datapath's feature-map input.
- Takes a raster-order pixel stream (one pixel per valid cycle, row-major, stride 1, no padding).
- Buffers KY-1 lines plus a KX x KY window register and emits one complete KX*KY window per valid output cycle.
- Output packing matches the kernel input bus exactly, so ot_valid_o/ot_f_map_o connect directly to in_valid_i/f_map_i of a kernel instance.

Parameters:
- KX, 3, kernel width (columns); >= 2
- KY, 3, kernel height (rows); >= 2
- I_F_BW, 8, pixel bit width
- IX, 8, image width in pixels; >= KX
- IY, 8, image height in lines; >= KY

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- soft_reset_i  input  1  synchronous flush, same effect as reset, lower priority
- in_valid_i  input  1  in_pixel_i valid this cycle
- in_pixel_i  input  I_F_BW  pixel, raster order
- ot_valid_o  output  1  ot_f_map_o holds a complete window
- ot_f_map_o  output  KX*KY*I_F_BW  window, element (x,y) at bits [((KY*x)+y)*I_F_BW +: I_F_BW]
- ot_last_o  output  1  qualifies the final window of a frame
- ot_frame_done_o  output  1  one-cycle pulse, one cycle after the last pixel of a frame is accepted

Behaviour:
- Reset values, applied on reset or soft_reset_i at the clock edge: col_cnt=0, row_cnt=0, ot_valid_o=0, ot_last_o=0, ot_frame_done_o=0, window register and ot_f_map_o all zero.
- Line buffers are not reset. Stale content is never exposed because output validity depends only on the counters.
- Counters: col_cnt 0..IX-1 and row_cnt 0..IY-1 advance only on in_valid_i=1.
  - col_cnt wraps to 0 at IX-1 and increments row_cnt.
  - row_cnt wraps to 0 at IY-1, which ends the frame.
  - Counter widths are $clog2 of IX and IY, each with a minimum of 1.
- Line buffers: KY-1 buffers, each IX deep.
  - On an accepted pixel at column c, buffer k (k=0 oldest line) outputs its stored pixel from column c. That is the pixel at (row-(KY-1)+k, c).
  - Each buffer then shifts in the value from the next-newer buffer; the newest buffer takes in_pixel_i.
  - Implementation may be shift registers or RAM with a column-indexed pointer.
- Window register, on each accepted pixel:
  - Column x shifts to x-1; column 0 is discarded.
  - Column KX-1 is loaded with y=0..KY-2 from line buffers 0..KY-2 and y=KY-1 from in_pixel_i.
  - Result: element (x,y) = pixel(row-(KY-1)+y, col-(KX-1)+x). x=0 is leftmost, y=0 is top.
- Output valid: ot_valid_o is registered one cycle after the accepting edge and is 1 iff row_cnt >= KY-1 and col_cnt >= KX-1 for the accepted pixel. Latency is 1 cycle.
- ot_valid_o is 0 in any cycle following an edge with in_valid_i=0. It is a pulse per window, not held.
- ot_f_map_o holds its value when ot_valid_o=0. It changes only on accepted pixels.
- Windows per frame: (IX-KX+1)*(IY-KY+1).
- End of frame, for the accepted pixel at (IY-1, IX-1):
  - That window asserts ot_valid_o and ot_last_o together.
  - ot_frame_done_o pulses in the same cycle.
  - Counters return to 0, so the next pixel starts a new frame with no dead cycles.
- Line wrap: windows never straddle lines. Pixels at col < KX-1 only refill the window and produce no output.
- Idle gaps (in_valid_i=0 for any number of cycles) anywhere, including mid-line and between frames, leave all state unchanged. Output sequence is identical to gap-free input.
- Reset or soft_reset_i asserted mid-frame:
  - Discards the partial frame; counters return to 0.
  - No ot_last_o or ot_frame_done_o for the aborted frame.
  - in_valid_i in the reset cycle is ignored.
- Priority order: reset > soft_reset_i > in_valid_i.

Test Plan:
- IX=IY=4, KX=KY=3, pixels p=4*row+col (0..15), back-to-back.
  - Response: 4 windows, ot_valid_o high the cycle after pixels 10, 11, 14, 15.
  - First window is {0,1,2,4,5,6,8,9,10} with element (x,y)=4*y+x.
  - ot_last_o=1 only with the window after pixel 15, whose (0,0)=5 and (2,2)=15.
  - ot_frame_done_o pulses once, in the same cycle.
- Same frame with random 0-3 idle cycles between pixels.
  - Response: identical 4 windows in the same order, ot_valid_o never high on consecutive idle-following cycles.
- Two frames back-to-back (second frame p+100).
  - Response: 8 windows; second-frame first window (0,0)=100, (2,2)=110; no cross-frame pixel mixing.
- reset asserted after pixel 9, then a full frame.
  - Response: ot_valid_o=0 and ot_f_map_o=0 the cycle after reset; next frame produces exactly 4 correct windows.
  - Same check repeated with soft_reset_i instead of reset.
- Pixels 0..9 only, then idle for 20 cycles.
  - Response: no ot_valid_o until pixel 10 arrives; window correct after resume.
- IX=8, IY=8, KX=KY=3, random pixels, kernel instance attached, 3 frames.
  - Response: 36 windows per frame; each kernel result equals the reference convolution sum.
